cpu_control_sequencer: RTL and testbench

- Multi-cycle control sequencer for the 16-bit CPU.
- Drives the 3-bit `state` bus consumed by the 8x16 register file: reads occur in DECODE (3'b001), writes in WRITEBACK (3'b100).
- Holds the instruction register, decodes register-address fields and sequences memory handshakes.
- Raises a fault if memory stalls past a limit.

---
 rtl/cpu_pkg.sv | 39 +++
 rtl/cpu_instr_decode.sv | 28 ++
 rtl/cpu_control_sequencer.sv | 146 ++++++++++++++
 tb/tb_cpu_control_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle CPU control sequencer:
// state codes, opcodes, instruction field positions and decode bundle.
package cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH     = 3'b000,
        ST_DECODE    = 3'b001,
        ST_EXECUTE   = 3'b010,
        ST_MEMORY    = 3'b011,
        ST_WRITEBACK = 3'b100,
        ST_HALTED    = 3'b111
    } state_e;

    localparam logic [3:0] OP_LOAD   = 4'h8;
    localparam logic [3:0] OP_STORE  = 4'h9;
    localparam logic [3:0] OP_BRANCH = 4'hA;
    localparam logic [3:0] OP_HALT   = 4'hF;

    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 9;
    localparam int RS1_MSB = 8;
    localparam int RS1_LSB = 6;
    localparam int RS2_MSB = 5;
    localparam int RS2_LSB = 3;

    localparam int MEM_TIMEOUT_DEF = 255;

    typedef struct packed {
        logic is_alu;
        logic is_load;
        logic is_store;
        logic is_branch;
        logic is_halt;
        logic writes_rd;
    } dec_t;

endpackage

// File: rtl/cpu_instr_decode.sv
// Opcode classifier: maps the IR opcode field to instruction class flags.
// Unlisted opcodes decode to all-zero, i.e. a NOP.
module cpu_instr_decode
    import cpu_pkg::*;
(
    input  logic [3:0] op_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '0;
        unique case (1'b1)
            !op_i[3]: begin
                dec_o.is_alu    = 1'b1;
                dec_o.writes_rd = 1'b1;
            end
            (op_i == OP_LOAD): begin
                dec_o.is_load   = 1'b1;
                dec_o.writes_rd = 1'b1;
            end
            (op_i == OP_STORE):  dec_o.is_store  = 1'b1;
            (op_i == OP_BRANCH): dec_o.is_branch = 1'b1;
            (op_i == OP_HALT):   dec_o.is_halt   = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/cpu_control_sequencer.sv
// Multi-cycle control FSM, instruction register and memory wait watchdog.
// Optional macro CPU_RETIRE_COUNT_EN adds the retired_count output.
module cpu_control_sequencer
    import cpu_pkg::*;
#(
    parameter int DATA_WIDTH     = 16,
    parameter int REG_ADDR_WIDTH = 3,
    parameter int MEM_TIMEOUT    = MEM_TIMEOUT_DEF
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [DATA_WIDTH-1:0]     instr,
    input  logic                      mem_ready,
    input  logic                      branch_taken,
    input  logic                      halt_req,
    output logic [2:0]                state,
    output logic [DATA_WIDTH-1:0]     ir,
    output logic [REG_ADDR_WIDTH-1:0] rf_read_address_1,
    output logic [REG_ADDR_WIDTH-1:0] rf_read_address_2,
    output logic [REG_ADDR_WIDTH-1:0] rf_write_address,
    output logic                      rf_write,
    output logic                      mem_read,
    output logic                      mem_write,
    output logic                      pc_inc,
    output logic                      pc_load,
    output logic                      fault
`ifdef CPU_RETIRE_COUNT_EN
    ,
    output logic [31:0]               retired_count
`endif
);

    localparam int CW = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  fault_q, fault_d;
    logic                  waiting;
    logic                  take_br;
    logic [DATA_WIDTH-1:0] ir_vis;
    dec_t                  dec;

    cpu_instr_decode u_dec (
        .op_i  (ir_q[OP_MSB:OP_LSB]),
        .dec_o (dec)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_FETCH;
            ir_q    <= '0;
            cnt_q   <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ir_q    <= ir_d;
            cnt_q   <= cnt_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        cnt_d     = '0;
        fault_d   = fault_q;
        waiting   = 1'b0;
        take_br   = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        rf_write  = 1'b0;
        pc_inc    = 1'b0;
        pc_load   = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    ir_d    = instr;
                    state_d = ST_DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            ST_DECODE: state_d = ST_EXECUTE;
            ST_EXECUTE: begin
                if (dec.is_load || dec.is_store)
                    state_d = ST_MEMORY;
                else if (dec.is_halt)
                    state_d = ST_HALTED;
                else
                    state_d = ST_WRITEBACK;
            end
            ST_MEMORY: begin
                mem_read  = dec.is_load;
                mem_write = dec.is_store;
                if (mem_ready)
                    state_d = ST_WRITEBACK;
                else
                    waiting = 1'b1;
            end
            ST_WRITEBACK: begin
                take_br  = dec.is_branch & branch_taken;
                rf_write = dec.writes_rd;
                pc_load  = take_br;
                pc_inc   = ~take_br;
                state_d  = halt_req ? ST_HALTED : ST_FETCH;
            end
            ST_HALTED: ;
            default: state_d = ST_FETCH;
        endcase
        // mem_ready on the limit cycle takes the normal path above
        if (waiting) begin
            if (cnt_q == LIMIT) begin
                fault_d = 1'b1;
                state_d = ST_HALTED;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    assign ir_vis = (state_q == ST_HALTED) ? '0 : ir_q;

    assign state             = state_q;
    assign ir                = ir_vis;
    assign rf_read_address_1 = ir_vis[RS1_MSB:RS1_LSB];
    assign rf_read_address_2 = ir_vis[RS2_MSB:RS2_LSB];
    assign rf_write_address  = ir_vis[RD_MSB:RD_LSB];
    assign fault             = fault_q;

`ifdef CPU_RETIRE_COUNT_EN
    logic [31:0] ret_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ret_q <= '0;
        else if (state_q == ST_WRITEBACK)
            ret_q <= ret_q + 32'd1;
    end

    assign retired_count = ret_q;
`endif

endmodule

// File: tb/tb_cpu_control_sequencer.sv
// Randomised scoreboard bench for cpu_control_sequencer.
// Expected per-cycle outputs come from an instruction-level timing model.
module tb_cpu_control_sequencer;

    localparam int TIMEOUT = 255;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] instr = '0;
    logic        mem_ready = 1'b0;
    logic        branch_taken = 1'b0;
    logic        halt_req = 1'b0;
    logic [2:0]  state;
    logic [15:0] ir;
    logic [2:0]  rf_read_address_1;
    logic [2:0]  rf_read_address_2;
    logic [2:0]  rf_write_address;
    logic        rf_write;
    logic        mem_read;
    logic        mem_write;
    logic        pc_inc;
    logic        pc_load;
    logic        fault;
`ifdef CPU_RETIRE_COUNT_EN
    logic [31:0] retired_count;
`endif

    always #5 clk = ~clk;

    cpu_control_sequencer dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .instr             (instr),
        .mem_ready         (mem_ready),
        .branch_taken      (branch_taken),
        .halt_req          (halt_req),
        .state             (state),
        .ir                (ir),
        .rf_read_address_1 (rf_read_address_1),
        .rf_read_address_2 (rf_read_address_2),
        .rf_write_address  (rf_write_address),
        .rf_write          (rf_write),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .pc_inc            (pc_inc),
        .pc_load           (pc_load),
        .fault             (fault)
`ifdef CPU_RETIRE_COUNT_EN
        ,
        .retired_count     (retired_count)
`endif
    );

    typedef struct packed {
        logic [2:0]  st;
        logic [15:0] ir;
        logic [2:0]  ra1;
        logic [2:0]  ra2;
        logic [2:0]  wa;
        logic        mr;
        logic        mw;
        logic        rfw;
        logic        pci;
        logic        pcl;
        logic        flt;
        logic [31:0] ret;
    } obs_t;

    typedef struct {
        logic [15:0] instr;
        logic        rdy;
        logic        bt;
        logic        hr;
        logic        rst;
        obs_t        exp;
    } stim_t;

    stim_t stim_q[$];
    obs_t  exp_q[$];
    int    checks = 0;
    int    errors = 0;
    int    cyc = 0;

    logic [15:0] m_ir;
    logic        m_flt;
    logic [31:0] m_ret;
    bit          m_halt;

    function automatic obs_t mk(input logic [2:0] s, input logic mr,
                                input logic mw, input logic rfw,
                                input logic pci, input logic pcl);
        obs_t o;
        logic [15:0] v;
        v = (s == 3'd7) ? 16'h0 : m_ir;
        o.st  = s;
        o.ir  = v;
        o.ra1 = v[8:6];
        o.ra2 = v[5:3];
        o.wa  = v[11:9];
        o.mr  = mr;
        o.mw  = mw;
        o.rfw = rfw;
        o.pci = pci;
        o.pcl = pcl;
        o.flt = m_flt;
`ifdef CPU_RETIRE_COUNT_EN
        o.ret = m_ret;
`else
        o.ret = '0;
`endif
        return o;
    endfunction

    function automatic logic r1();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic logic [15:0] r16();
        return 16'($urandom);
    endfunction

    task automatic push(input logic [15:0] w, input logic rdy,
                        input logic bt, input logic hr,
                        input logic rst, input obs_t e);
        stim_t s;
        s.instr = w;
        s.rdy   = rdy;
        s.bt    = bt;
        s.hr    = hr;
        s.rst   = rst;
        s.exp   = e;
        stim_q.push_back(s);
    endtask

    task automatic gen_reset();
        m_ir   = '0;
        m_flt  = 1'b0;
        m_ret  = '0;
        m_halt = 1'b0;
        push(r16(), r1(), r1(), r1(), 1'b1, mk(3'd0, 1, 0, 0, 0, 0));
    endtask

    task automatic gen_halted(input int n);
        for (int i = 0; i < n; i++)
            push(r16(), r1(), r1(), r1(), 1'b0, mk(3'd7, 0, 0, 0, 0, 0));
    endtask

    // f/m: cycles without mem_ready before the handshake in FETCH/MEMORY
    task automatic gen_instr(input logic [15:0] w, input int f,
                             input int m, input logic bt,
                             input logic hwb, input logic abort);
        logic [3:0] op;
        logic is_ld, is_st, is_br, is_hl, wr, pcl;
        op    = w[15:12];
        is_ld = (op == 4'h8);
        is_st = (op == 4'h9);
        is_br = (op == 4'hA);
        is_hl = (op == 4'hF);
        wr    = !op[3] || is_ld;
        for (int i = 0; i < f && i < TIMEOUT; i++)
            push(r16(), 0, r1(), r1(), 0, mk(3'd0, 1, 0, 0, 0, 0));
        if (f >= TIMEOUT) begin
            m_flt  = 1'b1;
            m_halt = 1'b1;
            return;
        end
        push(w, 1, r1(), r1(), 0, mk(3'd0, 1, 0, 0, 0, 0));
        m_ir = w;
        push(r16(), r1(), r1(), r1(), 0, mk(3'd1, 0, 0, 0, 0, 0));
        push(r16(), r1(), r1(), r1(), 0, mk(3'd2, 0, 0, 0, 0, 0));
        if (is_ld || is_st) begin
            for (int i = 0; i < m && i < TIMEOUT; i++)
                push(r16(), 0, r1(), r1(), 0,
                     mk(3'd3, is_ld, is_st, 0, 0, 0));
            if (m >= TIMEOUT) begin
                m_flt  = 1'b1;
                m_halt = 1'b1;
                return;
            end
            push(r16(), 1, r1(), r1(), 0, mk(3'd3, is_ld, is_st, 0, 0, 0));
        end else if (is_hl) begin
            m_halt = 1'b1;
            return;
        end
        pcl = is_br && bt;
        if (abort) begin
            m_ir  = '0;
            m_flt = 1'b0;
            m_ret = '0;
            push(r16(), r1(), bt, hwb, 1, mk(3'd0, 1, 0, 0, 0, 0));
            return;
        end
        push(r16(), r1(), bt, hwb, 0, mk(3'd4, 0, 0, wr, !pcl, pcl));
        m_ret = m_ret + 32'd1;
        if (hwb)
            m_halt = 1'b1;
    endtask

    task automatic recover();
        if (m_halt) begin
            gen_halted(3);
            gen_reset();
        end
    endtask

    obs_t got;
    always_comb begin
        got.st  = state;
        got.ir  = ir;
        got.ra1 = rf_read_address_1;
        got.ra2 = rf_read_address_2;
        got.wa  = rf_write_address;
        got.mr  = mem_read;
        got.mw  = mem_write;
        got.rfw = rf_write;
        got.pci = pc_inc;
        got.pcl = pc_load;
        got.flt = fault;
`ifdef CPU_RETIRE_COUNT_EN
        got.ret = retired_count;
`else
        got.ret = '0;
`endif
    end

    always @(negedge clk) begin
        obs_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks = checks + 1;
            if (got !== e) begin
                errors = errors + 1;
                $display({"FAIL cycle %0d outputs: got st=%0d ir=%h ra=%0d/%0d ",
                          "wa=%0d mr=%b mw=%b rfw=%b pci=%b pcl=%b flt=%b ret=%0d; ",
                          "want st=%0d ir=%h ra=%0d/%0d wa=%0d mr=%b mw=%b rfw=%b ",
                          "pci=%b pcl=%b flt=%b ret=%0d"},
                         cyc, got.st, got.ir, got.ra1, got.ra2, got.wa, got.mr,
                         got.mw, got.rfw, got.pci, got.pcl, got.flt, got.ret,
                         e.st, e.ir, e.ra1, e.ra2, e.wa, e.mr, e.mw, e.rfw,
                         e.pci, e.pcl, e.flt, e.ret);
            end
        end
    end

    initial begin
        stim_t s;
        int    n;
        gen_reset();
        gen_instr(16'h0298, 0, 0, 0, 0, 0);
        gen_instr(16'h8A00, 1, 3, 0, 0, 0);
        gen_instr(16'h9000, 0, 0, 0, 0, 0);
        gen_instr(16'hA000, 0, 0, 1, 0, 0);
        gen_instr(16'hA000, 0, 0, 0, 0, 0);
        gen_instr(16'h0298, TIMEOUT - 1, 0, 0, 0, 0);
        gen_instr(16'h1234, TIMEOUT + 40, 0, 0, 0, 0);
        recover();
        gen_instr(16'h8E40, 0, TIMEOUT - 1, 0, 0, 0);
        gen_instr(16'h9000, 0, TIMEOUT + 10, 0, 0, 0);
        recover();
        gen_instr(16'hF000, 0, 0, 0, 0, 0);
        recover();
        gen_instr(16'h1111, 0, 0, 0, 0, 0);
        gen_instr(16'h2222, 2, 0, 0, 0, 0);
        gen_instr(16'h3333, 0, 0, 0, 1, 0);
        recover();
        gen_instr(16'h0E38, 0, 0, 0, 0, 1);
        for (int i = 0; i < 80; i++) begin
            int f, m;
            f = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0;
            m = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4)) : 0;
            gen_instr(r16(), f, m, r1(),
                      $urandom_range(0, 9) == 0,
                      $urandom_range(0, 11) == 0);
            recover();
        end

        while (stim_q.size() != 0) begin
            @(posedge clk);
            #1;
            s = stim_q.pop_front();
            cyc = cyc + 1;
            instr        = s.instr;
            mem_ready    = s.rdy;
            branch_taken = s.bt;
            halt_req     = s.hr;
            exp_q.push_back(s.exp);
            if (!s.rst)
                reset_n = 1'b1;
            else begin
                #1;
                reset_n = 1'b0;
            end
        end

        n = 0;
        while (exp_q.size() != 0 && n < 10) begin
            @(negedge clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            errors = errors + 1;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
